sd_spi_block_read: RTL

//  Single-block (512 B) SD read over SPI (CMD17), downstream of SD SPI init; enabled once sd_init_done=1.
//  On a start request it sends CMD17, waits for R1 and the 0xFE start token, and streams 512 data bytes.

---
 rtl/sd_spi_block_read.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sd_spi_block_read.sv
// SD card single-block (CMD17) reader over SPI mode 0; streams 512 data bytes as one-cycle strobes.
// Drives the shared SPI bus only while rd_busy is high; CRC bytes are clocked in and dropped.
module sd_spi_block_read #(
    parameter int CLK_DIV       = 4,
    parameter int SDHC          = 1,
    parameter int R1_TIMEOUT    = 16,
    parameter int TOKEN_TIMEOUT = 25000
) (
    input  logic        clk_sd,
    input  logic        reset_n,
    input  logic        sd_init_done,
    input  logic        rd_start,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_busy,
    input  logic        sd_spi_miso,
    output logic        sd_spi_clk,
    output logic        sd_spi_cs,
    output logic        sd_spi_mosi,
    output logic [7:0]  rd_data,
    output logic        rd_data_valid,
    output logic        rd_done,
    output logic        rd_error,
    output logic [1:0]  rd_err_code
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int R1_W  = $clog2(R1_TIMEOUT + 1);
    localparam int TOK_W = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(CLK_DIV - 1);
    localparam logic [R1_W-1:0]  R1_LAST  = R1_W'(R1_TIMEOUT - 1);
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(TOKEN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, FINISH, DONE
    } state_t;

    state_t           state, state_next;
    logic [1:0]       code_next;
    logic [DIV_W-1:0] div;
    logic [2:0]       bit_cnt;
    logic [47:0]      tx_shift;
    logic [7:0]       rx_shift;
    logic [2:0]       byte_cnt;
    logic [R1_W-1:0]  r1_cnt;
    logic [TOK_W-1:0] tok_cnt;
    logic [9:0]       data_cnt;
    logic             byte_pending;
    logic             running, rise_evt, fall_evt, byte_end, accept;
    logic [31:0]      cmd_arg;

    assign running  = (state != IDLE) && (state != DONE);
    assign rise_evt = running && (div == RISE_AT);
    assign fall_evt = running && (div == FALL_AT);
    // Byte decisions are taken on the falling edge that closes the byte, when rx_shift is complete.
    assign byte_end = fall_evt && (bit_cnt == 3'd7);
    assign accept   = (state == IDLE) && rd_start && sd_init_done;
    assign cmd_arg  = (SDHC != 0) ? rd_sec_addr : {rd_sec_addr[22:0], 9'd0};

    assign rd_busy     = (state != IDLE);
    assign sd_spi_cs   = !(state inside {SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC});
    assign sd_spi_mosi = tx_shift[47];
    assign rd_done     = (state == DONE);
    assign rd_error    = rd_done && (rd_err_code != 2'd0);

    always_comb begin
        state_next = state;
        code_next  = rd_err_code;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND_CMD;
                    code_next  = 2'd0;
                end
            end
            SEND_CMD: begin
                if (byte_end && byte_cnt == 3'd5) state_next = WAIT_R1;
            end
            WAIT_R1: begin
                if (byte_end) begin
                    if (!rx_shift[7]) begin
                        if (rx_shift == 8'h00) begin
                            state_next = WAIT_TOKEN;
                        end else begin
                            state_next = FINISH;
                            code_next  = 2'd1;
                        end
                    end else if (r1_cnt == R1_LAST) begin
                        state_next = FINISH;
                        code_next  = 2'd2;
                    end
                end
            end
            WAIT_TOKEN: begin
                if (byte_end) begin
                    if (rx_shift == 8'hFE) begin
                        state_next = READ_DATA;
                    end else if (rx_shift[7:4] == 4'h0 || tok_cnt == TOK_LAST) begin
                        state_next = FINISH;
                        code_next  = 2'd3;
                    end
                end
            end
            READ_DATA: begin
                if (byte_end && data_cnt == 10'd511) state_next = READ_CRC;
            end
            READ_CRC: begin
                if (byte_end && byte_cnt == 3'd1) state_next = FINISH;
            end
            FINISH: begin
                if (byte_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            state         <= IDLE;
            rd_err_code   <= 2'd0;
            div           <= '0;
            bit_cnt       <= 3'd0;
            sd_spi_clk    <= 1'b0;
            tx_shift      <= '1;
            rx_shift      <= 8'd0;
            byte_pending  <= 1'b0;
            rd_data       <= 8'd0;
            rd_data_valid <= 1'b0;
            byte_cnt      <= 3'd0;
            r1_cnt        <= '0;
            tok_cnt       <= '0;
            data_cnt      <= 10'd0;
        end else begin
            state         <= state_next;
            rd_err_code   <= code_next;
            rd_data_valid <= 1'b0;
            byte_pending  <= 1'b0;
            if (accept) tx_shift <= {8'h51, cmd_arg, 8'hFF};

            if (!running) begin
                div        <= '0;
                bit_cnt    <= 3'd0;
                sd_spi_clk <= 1'b0;
            end else begin
                div <= fall_evt ? '0 : div + DIV_W'(1);
                if (rise_evt) begin
                    sd_spi_clk   <= 1'b1;
                    rx_shift     <= {rx_shift[6:0], sd_spi_miso};
                    byte_pending <= (bit_cnt == 3'd7) && (state == READ_DATA);
                end
                if (byte_pending) begin
                    rd_data       <= rx_shift;
                    rd_data_valid <= 1'b1;
                end
                // MOSI refills with ones, so everything after the command frame clocks out 0xFF.
                if (fall_evt) begin
                    sd_spi_clk <= 1'b0;
                    bit_cnt    <= bit_cnt + 3'd1;
                    tx_shift   <= {tx_shift[46:0], 1'b1};
                end
            end

            if (state_next != state) begin
                byte_cnt <= 3'd0;
                r1_cnt   <= '0;
                tok_cnt  <= '0;
                data_cnt <= 10'd0;
            end else if (byte_end) begin
                case (state)
                    SEND_CMD, READ_CRC: byte_cnt <= byte_cnt + 3'd1;
                    WAIT_R1:            r1_cnt   <= r1_cnt + R1_W'(1);
                    WAIT_TOKEN:         tok_cnt  <= tok_cnt + TOK_W'(1);
                    READ_DATA:          data_cnt <= data_cnt + 10'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule
